// File: rtl/score_readout.sv
// Score RAM reader: scans all slots for the highest score and its slot, then
// converts that score to three BCD digits for the seven-segment display path.
module score_readout #(
  parameter int NUM_SLOTS = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] read_data_i,
  output logic [3:0] read_address_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] high_score_o,
  output logic [3:0] high_address_o,
  output logic [3:0] hundreds_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    DRAIN   = 3'd2,
    CONVERT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'(NUM_SLOTS - 1);

  // One double-dabble iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5) begin
        t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
      end else begin
        t[8 + 4*i +: 4] = t[8 + 4*i +: 4];
      end
    end
    return {t[18:0], 1'b0};
  endfunction

  state_t      state_q;
  logic [3:0]  addr_q;
  logic [7:0]  max_q;
  logic [3:0]  max_addr_q;
  logic [19:0] conv_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  high_score_q;
  logic [3:0]  high_addr_q;
  logic [3:0]  hundreds_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;

  logic        cap_en_s;
  logic [3:0]  tag_s;
  logic [7:0]  max_d;
  logic [3:0]  max_addr_d;
  logic [19:0] conv_d;

  // Read data belongs to the address presented one cycle earlier.
  always_comb begin
    cap_en_s   = ((state_q == READ) && (addr_q != 4'd0)) || (state_q == DRAIN);
    tag_s      = (state_q == DRAIN) ? LAST_ADDR : (addr_q - 4'd1);
    max_d      = max_q;
    max_addr_d = max_addr_q;
    if (cap_en_s && (read_data_i > max_q)) begin
      max_d      = read_data_i;
      max_addr_d = tag_s;
    end else begin
      max_d      = max_q;
      max_addr_d = max_addr_q;
    end
    conv_d = dabble_step(conv_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= 4'd0;
      max_q        <= 8'd0;
      max_addr_q   <= 4'd0;
      conv_q       <= 20'd0;
      cnt_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      high_score_q <= 8'd0;
      high_addr_q  <= 4'd0;
      hundreds_q   <= 4'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          addr_q <= 4'd0;
          if (start_i) begin
            state_q    <= READ;
            max_q      <= 8'd0;
            max_addr_q <= 4'd0;
            busy_q     <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        READ: begin
          max_q      <= max_d;
          max_addr_q <= max_addr_d;
          if (addr_q == LAST_ADDR) begin
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 4'd1;
          end
        end
        DRAIN: begin
          max_q      <= max_d;
          max_addr_q <= max_addr_d;
          conv_q     <= {12'd0, max_d};
          cnt_q      <= 3'd0;
          state_q    <= CONVERT;
        end
        CONVERT: begin
          conv_q <= conv_d;
          cnt_q  <= cnt_q + 3'd1;
          // Final iteration: publish results as DONE is entered.
          if (cnt_q == 3'd7) begin
            state_q      <= DONE;
            done_q       <= 1'b1;
            high_score_q <= max_q;
            high_addr_q  <= max_addr_q;
            hundreds_q   <= conv_d[19:16];
            tens_q       <= conv_d[15:12];
            ones_q       <= conv_d[11:8];
          end else begin
            state_q <= CONVERT;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= 4'd0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          addr_q  <= 4'd0;
        end
      endcase
    end
  end

  assign read_address_o = addr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign high_score_o   = high_score_q;
  assign high_address_o = high_addr_q;
  assign hundreds_o     = hundreds_q;
  assign tens_o         = tens_q;
  assign ones_o         = ones_q;

endmodule

// File: tb/tb_score_readout.sv
// Directed bench for score_readout with a synchronous-read RAM model.
module tb_score_readout;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] read_data_i;
  logic [3:0] read_address_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] high_score_o;
  logic [3:0] high_address_o;
  logic [3:0] hundreds_o;
  logic [3:0] tens_o;
  logic [3:0] ones_o;

  logic [7:0] ram [16];
  int vec = 0;
  int errs = 0;
  logic [7:0] prev_hs = 8'd0;
  logic [3:0] prev_ha = 4'd0;

  score_readout #(.NUM_SLOTS(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .read_data_i(read_data_i), .read_address_o(read_address_o),
    .busy_o(busy_o), .done_o(done_o),
    .high_score_o(high_score_o), .high_address_o(high_address_o),
    .hundreds_o(hundreds_o), .tens_o(tens_o), .ones_o(ones_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) read_data_i <= ram[read_address_o];

  task automatic load_pattern1();
    logic [7:0] p [16];
    p = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd50, 8'd199, 8'd0,
          8'd12, 8'd100, 8'd150, 8'd8, 8'd5, 8'd42, 8'd77, 8'd0};
    for (int i = 0; i < 16; i++) ram[i] = p[i];
  endtask

  // Start pulse, then watch cycles 1..30 relative to the accepting edge.
  task automatic run_scan(input string name, input bit repulse,
                          input logic [7:0] e_hs, input logic [3:0] e_ha,
                          input logic [3:0] e_h, input logic [3:0] e_t, input logic [3:0] e_o);
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = -1;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      vec++;
      if (busy_o !== logic'(cyc <= 26)) begin
        errs++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, cyc, busy_o, (cyc <= 26));
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc < 26) begin
        vec++;
        if (high_score_o !== prev_hs || high_address_o !== prev_ha) begin
          errs++;
          $display("FAIL %s hold cycle %0d: got %0d/%0d want %0d/%0d", name, cyc,
                   high_score_o, high_address_o, prev_hs, prev_ha);
        end
      end
      start_i = repulse && (cyc == 4 || cyc == 26);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    vec++;
    if (done_cnt !== 1 || done_cyc !== 26) begin
      errs++;
      $display("FAIL %s done: got count %0d at cycle %0d want 1 at 26", name, done_cnt, done_cyc);
    end
    vec++;
    if (high_score_o !== e_hs || high_address_o !== e_ha) begin
      errs++;
      $display("FAIL %s result: got %0d@%0d want %0d@%0d", name, high_score_o, high_address_o, e_hs, e_ha);
    end
    vec++;
    if ({hundreds_o, tens_o, ones_o} !== {e_h, e_t, e_o}) begin
      errs++;
      $display("FAIL %s bcd: got %0d%0d%0d want %0d%0d%0d", name, hundreds_o, tens_o, ones_o, e_h, e_t, e_o);
    end
    prev_hs = e_hs;
    prev_ha = e_ha;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'd0;
    repeat (3) @(negedge clk_i);
    vec++;
    if ({read_address_o, busy_o, done_o, high_score_o, high_address_o, hundreds_o, tens_o, ones_o} !== 34'd0) begin
      errs++;
      $display("FAIL reset outputs: got addr %0d busy %b done %b hs %0d ha %0d", read_address_o, busy_o,
               done_o, high_score_o, high_address_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_max();
    load_pattern1();
    run_scan("single_max", 1'b0, 8'd200, 4'd3, 4'd2, 4'd0, 4'd0);
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 16; i++) ram[i] = 8'd0;
    run_scan("all_zero", 1'b0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_tie();
    for (int i = 0; i < 16; i++) ram[i] = 8'(i * 10);
    ram[5] = 8'd255;
    ram[12] = 8'd255;
    run_scan("tie", 1'b0, 8'd255, 4'd5, 4'd2, 4'd5, 4'd5);
  endtask

  task automatic test_back_to_back();
    load_pattern1();
    run_scan("ignored_start", 1'b1, 8'd200, 4'd3, 4'd2, 4'd0, 4'd0);
    run_scan("second_scan", 1'b0, 8'd200, 4'd3, 4'd2, 4'd0, 4'd0);
  endtask

  task automatic test_update();
    for (int i = 0; i < 15; i++) ram[i] = 8'(i * 5);
    ram[15] = 8'd99;
    run_scan("update", 1'b0, 8'd99, 4'd15, 4'd0, 4'd9, 4'd9);
  endtask

  task automatic test_start_held();
    int first;
    int second;
    int cnt;
    first = -1;
    second = -1;
    cnt = 0;
    load_pattern1();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done_o === 1'b1) begin
        cnt++;
        if (first < 0) first = cyc; else if (second < 0) second = cyc;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    vec++;
    if (cnt !== 2 || first !== 26 || second !== 53) begin
      errs++;
      $display("FAIL start_held: got %0d dones at %0d,%0d want 2 at 26,53", cnt, first, second);
    end
    repeat (40) @(negedge clk_i);
    prev_hs = 8'd200;
    prev_ha = 4'd3;
  endtask

  task automatic test_reset_midscan();
    int dones;
    dones = 0;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    vec++;
    if ({read_address_o, busy_o, done_o, high_score_o, high_address_o, hundreds_o, tens_o, ones_o} !== 34'd0) begin
      errs++;
      $display("FAIL midscan_reset outputs: got addr %0d busy %b hs %0d ha %0d digits %0d%0d%0d",
               read_address_o, busy_o, high_score_o, high_address_o, hundreds_o, tens_o, ones_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) dones++;
    end
    rst_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) dones++;
    end
    vec++;
    if (dones !== 0) begin
      errs++;
      $display("FAIL midscan_reset done: got %0d pulses want 0", dones);
    end
    prev_hs = 8'd0;
    prev_ha = 4'd0;
    run_scan("after_reset", 1'b0, 8'd200, 4'd3, 4'd2, 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_single_max();
    test_all_zero();
    test_tie();
    test_back_to_back();
    test_update();
    test_start_held();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/score_readout.md
# score_readout

Reader side of the score RAM: on request, scans every score slot via the RAM read port, finds the highest score and its slot, and converts that score to three BCD digits for the seven-segment display path. Sits between the score RAM (written by the score-update logic) and the display driver, sharing the RAM's 4-bit address / 8-bit data format.

## Interface
- NUM_SLOTS, default 16; number of RAM slots scanned, legal range 1..16; slots 0..NUM_SLOTS-1.
- Clk  input  1  single clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- Start  input  1  scan request, sampled only in IDLE.
- ReadData  input  8  RAM read data; synchronous-read RAM, data for the address driven in cycle c is valid during cycle c+1.
- ReadAddress  output  4  RAM read address.
- Busy  output  1  high from the cycle after Start is accepted through the DONE cycle.
- Done  output  1  one-cycle pulse, results valid.
- HighScore  output  8  highest score found.
- HighAddress  output  4  slot holding HighScore.
- Hundreds, Tens, Ones  output  4 each  BCD digits of HighScore.

## Operation
- States: IDLE, READ, DRAIN, CONVERT, DONE.
- IDLE: Busy=0, ReadAddress=0. Start=1 at an edge -> READ, ReadAddress=0, running max and running address cleared to 0.
- READ: ReadAddress increments by 1 each cycle, 0..NUM_SLOTS-1, then -> DRAIN. No wrap past NUM_SLOTS-1.
- Capture: every cycle from the second READ cycle through DRAIN, ReadData is compared with the running max, tagged with the address presented one cycle earlier.
- Compare: strictly greater replaces max and its address; ties keep the earlier (lowest) address. Unsigned 8-bit compare.
- DRAIN: one cycle; captures data for slot NUM_SLOTS-1; ReadAddress holds NUM_SLOTS-1.
- CONVERT: 8 iterations of shift-and-add-3 (double dabble) on the running max, one bit per cycle, into a 12-bit BCD register. Add 3 to any digit >=5 before each shift.
- DONE: HighScore, HighAddress, Hundreds, Tens and Ones are loaded from the internal registers; Done=1 for this cycle only -> IDLE.
- Result outputs change only on entry to DONE and hold between scans. A new scan does not disturb them until its own DONE.
- Start while Busy, including the DONE cycle, is ignored and not queued.
- Start held high continuously: a new scan begins in every IDLE cycle, i.e. one scan every NUM_SLOTS+11 cycles.

## Timing
- Cycle 0 is the edge at which Start is sampled high in IDLE.
- Cycles 1..NUM_SLOTS: READ, with ReadAddress = cycle-1.
- Cycle NUM_SLOTS+1: DRAIN.
- Cycles NUM_SLOTS+2..NUM_SLOTS+9: CONVERT.
- Cycle NUM_SLOTS+10: DONE, with Done=1 and results valid. With NUM_SLOTS=16, Done is high in cycle 26.
- Busy=1 in cycles 1..NUM_SLOTS+10. IDLE resumes in cycle NUM_SLOTS+11.
- Reset values: ReadAddress=0, Busy=0, Done=0, HighScore=0, HighAddress=0, Hundreds=Tens=Ones=0, state IDLE.
- Reset mid-scan: the scan aborts immediately and all outputs return to reset values. Done is not asserted for the aborted scan. A Start is accepted on the first edge after Reset deasserts.
- NUM_SLOTS=1: READ lasts 1 cycle; Done occurs in cycle 11.

## Test plan
- RAM slots 0..15 = 3,9,1,200,7,…,0 (max 200 only at slot 3), one Start pulse -> Done only in cycle 26; HighScore=200, HighAddress=3, digits 2/0/0; Busy high cycles 1..26.
- All slots 0 -> HighScore=0, HighAddress=0, digits 0/0/0.
- Slots 5 and 12 both hold 255, all others lower -> HighScore=255, HighAddress=5, digits 2/5/5.
- Start re-pulsed in cycles 4 and 26 -> both ignored, exactly one Done; then Start in IDLE -> second scan's Done lands 26 cycles later.
- Scan running with previous results 200/3 displayed; RAM changed so slot 15 = 99 and all others lower -> outputs stay at 200 until the new DONE, then 99/15, digits 0/9/9.
- Reset asserted in cycle 10 of a scan -> all outputs 0 immediately, no Done; Start after Reset deasserts -> a full correct scan.
